// File: rtl/mem_ctrl_fsm.sv
// Front-panel memory controller: key pulses and switches drive single 16-bit req/ack transactions.
// Optional AUTO_INC_EN: post-increment mem_addr after each ack and allow key_read re-read from READ_DONE.
module mem_ctrl_fsm #(
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_read,
  input  logic        key_write,
  input  logic        key_next,
  input  logic [7:0]  sw,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [12:0] state,
  output logic [15:0] rd_data,
  output logic        err
);

  // state      | meaning
  // RESET      | post-reset hold for RESET_CYCLES edges
  // IDLE       | waiting for key_read / key_write
  // READ_ST0   | address entry
  // READ_ST1/2 | request issued, ack not yet allowed
  // READ_WAIT  | waiting for ack or timeout
  // READ_DONE  | read word displayed
  // WRITE_ST0  | address entry
  // WRITE_ST3  | data low byte entry
  // WRITE_ST4  | data high byte entry
  // WRITE_ST1/2| request issued, ack not yet allowed
  // WRITE_WAIT | waiting for ack or timeout
  typedef enum logic [12:0] {
    S_RESET      = 13'h0001,
    S_IDLE       = 13'h0002,
    S_READ_ST0   = 13'h0004,
    S_READ_ST1   = 13'h0008,
    S_READ_ST2   = 13'h0010,
    S_READ_WAIT  = 13'h0020,
    S_READ_DONE  = 13'h0040,
    S_WRITE_ST0  = 13'h0080,
    S_WRITE_ST1  = 13'h0100,
    S_WRITE_ST2  = 13'h0200,
    S_WRITE_ST3  = 13'h0400,
    S_WRITE_ST4  = 13'h0800,
    S_WRITE_WAIT = 13'h1000
  } state_t;

  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      cur, nxt;
  logic [15:0] cnt, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= S_RESET;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      cur     <= nxt;
      cnt     <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    nxt     = cur;
    cnt_d   = cnt;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (cur)
      S_RESET: begin
        if (cnt == RST_LAST) begin
          nxt   = S_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (key_read) begin
          nxt   = S_READ_ST0;
          err_d = 1'b0;
        end else if (key_write) begin
          nxt   = S_WRITE_ST0;
          err_d = 1'b0;
        end
      end
      S_READ_ST0: begin
        if (key_next) begin
          addr_d = sw;
          nxt    = S_READ_ST1;
        end
      end
      S_READ_ST1: nxt = S_READ_ST2;
      S_READ_ST2: begin
        nxt   = S_READ_WAIT;
        cnt_d = '0;
      end
      S_READ_WAIT: begin
        // ack takes priority over a timeout in the same cycle
        if (mem_ack) begin
          rdata_d = mem_rdata;
          nxt     = S_READ_DONE;
          cnt_d   = '0;
`ifdef AUTO_INC_EN
          addr_d  = addr_q + 8'd1;
`endif
        end else if (cnt == TO_LAST) begin
          err_d = 1'b1;
          nxt   = S_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_READ_DONE: begin
        if (key_next) begin
          nxt = S_IDLE;
`ifdef AUTO_INC_EN
        end else if (key_read) begin
          nxt = S_READ_ST1;
`endif
        end
      end
      S_WRITE_ST0: begin
        if (key_next) begin
          addr_d  = sw;
          wdata_d = '0;
          nxt     = S_WRITE_ST3;
        end
      end
      S_WRITE_ST3: begin
        if (key_next) begin
          wdata_d[7:0] = sw;
          nxt          = S_WRITE_ST4;
        end
      end
      S_WRITE_ST4: begin
        if (key_next) begin
          wdata_d[15:8] = sw;
          nxt           = S_WRITE_ST1;
        end
      end
      S_WRITE_ST1: nxt = S_WRITE_ST2;
      S_WRITE_ST2: begin
        nxt   = S_WRITE_WAIT;
        cnt_d = '0;
      end
      S_WRITE_WAIT: begin
        if (mem_ack) begin
          nxt   = S_IDLE;
          cnt_d = '0;
`ifdef AUTO_INC_EN
          addr_d = addr_q + 8'd1;
`endif
        end else if (cnt == TO_LAST) begin
          err_d = 1'b1;
          nxt   = S_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: begin
        nxt   = S_RESET;
        cnt_d = '0;
      end
    endcase
    // request flags follow the next state so they line up with the registered state vector
    req_d = nxt inside {S_READ_ST1, S_READ_ST2, S_READ_WAIT,
                        S_WRITE_ST1, S_WRITE_ST2, S_WRITE_WAIT};
    we_d  = nxt inside {S_WRITE_ST1, S_WRITE_ST2, S_WRITE_WAIT};
  end

  assign state     = cur;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rd_data   = rdata_q;
  assign err       = err_q;

endmodule
